// File: rtl/alu_button_sequencer.sv
// Operand/opcode entry and execute block for the board-level ALU.
// Push-buttons are synchronised and edge-detected; A, B and the opcode are
// latched from the switches, and an execute request runs a one-cycle EXEC
// state that registers the result and status flags for the LEDs.
// Ports:
//   i_clk, i_reset         clock, synchronous active-high reset
//   i_switch               data/opcode switches (sampled directly at the action edge)
//   i_btn_a/_b/_op/_exec   asynchronous push-buttons
//   o_a, o_b, o_opcode     currently latched operands and opcode
//   o_result, o_zero, o_carry, o_overflow, o_err   last registered result/flags
//   o_valid                one-cycle pulse after a result is registered
//   o_busy                 high while the FSM is in EXEC
module alu_button_sequencer #(
  parameter int NB_DATA   = 8,
  parameter int NB_OPCODE = 6,
  parameter int NB_SYNC   = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NB_DATA-1:0]   i_switch,
  input  logic                 i_btn_a,
  input  logic                 i_btn_b,
  input  logic                 i_btn_op,
  input  logic                 i_btn_exec,
  output logic [NB_DATA-1:0]   o_a,
  output logic [NB_DATA-1:0]   o_b,
  output logic [NB_OPCODE-1:0] o_opcode,
  output logic [NB_DATA-1:0]   o_result,
  output logic                 o_zero,
  output logic                 o_carry,
  output logic                 o_overflow,
  output logic                 o_err,
  output logic                 o_valid,
  output logic                 o_busy
);

  typedef enum logic {ST_IDLE, ST_EXEC} state_t;

  localparam logic [NB_OPCODE-1:0] OP_ADD = NB_OPCODE'(6'b100000);
  localparam logic [NB_OPCODE-1:0] OP_SUB = NB_OPCODE'(6'b100010);
  localparam logic [NB_OPCODE-1:0] OP_AND = NB_OPCODE'(6'b100100);
  localparam logic [NB_OPCODE-1:0] OP_OR  = NB_OPCODE'(6'b100101);
  localparam logic [NB_OPCODE-1:0] OP_XOR = NB_OPCODE'(6'b100110);
  localparam logic [NB_OPCODE-1:0] OP_NOR = NB_OPCODE'(6'b100111);
  localparam logic [NB_OPCODE-1:0] OP_SRA = NB_OPCODE'(6'b000011);
  localparam logic [NB_OPCODE-1:0] OP_SRL = NB_OPCODE'(6'b000010);
  localparam logic [NB_DATA-1:0]   SHIFT_LIM = NB_DATA'(NB_DATA);

  // Button bit order everywhere: {exec, op, b, a}
  logic [3:0] btn_raw;
  logic [3:0] sync_q [NB_SYNC];
  logic [3:0] sync_d [NB_SYNC];
  logic [3:0] dly_q, dly_d;
  logic [3:0] btn_edge;

  state_t                 state_q, state_d;
  logic [NB_DATA-1:0]     a_q, a_d, b_q, b_d, snap_a_q, snap_a_d, snap_b_q, snap_b_d;
  logic [NB_OPCODE-1:0]   opcode_q, opcode_d, snap_op_q, snap_op_d;
  logic [NB_DATA-1:0]     result_q, result_d;
  logic                   zero_q, zero_d, carry_q, carry_d;
  logic                   overflow_q, overflow_d, err_q, err_d, valid_q, valid_d;

  logic [NB_DATA:0]       alu_sum;
  logic [NB_DATA-1:0]     alu_diff, alu_res;
  logic                   alu_c, alu_v, alu_e;

  assign btn_raw  = {i_btn_exec, i_btn_op, i_btn_b, i_btn_a};
  assign btn_edge = sync_q[NB_SYNC-1] & ~dly_q;

  always_comb begin
    sync_d[0] = btn_raw;
    for (int unsigned i = 1; i < NB_SYNC; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    dly_d = sync_q[NB_SYNC-1];
  end

  // ALU works only from the snapshot so in-flight results ignore later input changes
  always_comb begin
    alu_sum  = {1'b0, snap_a_q} + {1'b0, snap_b_q};
    alu_diff = snap_a_q - snap_b_q;
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    alu_e    = 1'b0;
    case (snap_op_q)
      OP_ADD: begin
        alu_res = alu_sum[NB_DATA-1:0];
        alu_c   = alu_sum[NB_DATA];
        alu_v   = (snap_a_q[NB_DATA-1] == snap_b_q[NB_DATA-1]) &&
                  (alu_res[NB_DATA-1] != snap_a_q[NB_DATA-1]);
      end
      OP_SUB: begin
        alu_res = alu_diff;
        alu_c   = (snap_a_q < snap_b_q);
        alu_v   = (snap_a_q[NB_DATA-1] != snap_b_q[NB_DATA-1]) &&
                  (alu_res[NB_DATA-1] != snap_a_q[NB_DATA-1]);
      end
      OP_AND: alu_res = snap_a_q & snap_b_q;
      OP_OR:  alu_res = snap_a_q | snap_b_q;
      OP_XOR: alu_res = snap_a_q ^ snap_b_q;
      OP_NOR: alu_res = ~(snap_a_q | snap_b_q);
      OP_SRA: begin
        if (snap_b_q >= SHIFT_LIM) alu_res = {NB_DATA{snap_a_q[NB_DATA-1]}};
        else                        alu_res = $unsigned($signed(snap_a_q) >>> snap_b_q);
      end
      OP_SRL: begin
        if (snap_b_q >= SHIFT_LIM) alu_res = '0;
        else                        alu_res = snap_a_q >> snap_b_q;
      end
      default: alu_e = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    opcode_d   = opcode_q;
    snap_a_d   = snap_a_q;
    snap_b_d   = snap_b_q;
    snap_op_d  = snap_op_q;
    result_d   = result_q;
    zero_d     = zero_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    err_d      = err_q;
    valid_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Fixed priority; losing coincident edges are simply discarded
        if (btn_edge[0])      a_d      = i_switch;
        else if (btn_edge[1]) b_d      = i_switch;
        else if (btn_edge[2]) opcode_d = i_switch[NB_OPCODE-1:0];
        else if (btn_edge[3]) begin
          snap_a_d  = a_q;
          snap_b_d  = b_q;
          snap_op_d = opcode_q;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        result_d   = alu_res;
        zero_d     = (alu_res == '0);
        carry_d    = alu_c;
        overflow_d = alu_v;
        err_d      = alu_e;
        valid_d    = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < NB_SYNC; i++) sync_q[i] <= '0;
      dly_q      <= '0;
      state_q    <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      opcode_q   <= '0;
      snap_a_q   <= '0;
      snap_b_q   <= '0;
      snap_op_q  <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NB_SYNC; i++) sync_q[i] <= sync_d[i];
      dly_q      <= dly_d;
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      opcode_q   <= opcode_d;
      snap_a_q   <= snap_a_d;
      snap_b_q   <= snap_b_d;
      snap_op_q  <= snap_op_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
    end
  end

  assign o_a        = a_q;
  assign o_b        = b_q;
  assign o_opcode   = opcode_q;
  assign o_result   = result_q;
  assign o_zero     = zero_q;
  assign o_carry    = carry_q;
  assign o_overflow = overflow_q;
  assign o_err      = err_q;
  assign o_valid    = valid_q;
  assign o_busy     = (state_q == ST_EXEC);

endmodule

// File: doc/alu_button_sequencer.md
Name: alu_button_sequencer

Overview:
Parametrised next-generation operand/opcode entry and execute block for the board-level ALU.
- Takes asynchronous push-buttons and switches.
- Synchronises the buttons and detects their rising edges.
- Latches operand A, operand B and the opcode.
- On an execute request, runs a two-state FSM that computes a registered result and status flags (zero, carry, overflow, invalid-opcode) for LEDs.
- Sits between the board I/O pins and the LED/display drivers.

Parameters:
NB_DATA, 8, operand/result width (>=4).
NB_OPCODE, 6, opcode width; opcode taken from i_switch[NB_OPCODE-1:0] (requires NB_OPCODE <= NB_DATA).
NB_SYNC, 2, synchroniser flops per button (>=2).

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_switch  in  NB_DATA  data/opcode switches, asynchronous
i_btn_a  in  1  load operand A, asynchronous
i_btn_b  in  1  load operand B, asynchronous
i_btn_op  in  1  load opcode, asynchronous
i_btn_exec  in  1  execute request, asynchronous
o_a  out  NB_DATA  current operand A
o_b  out  NB_DATA  current operand B
o_opcode  out  NB_OPCODE  current opcode
o_result  out  NB_DATA  last registered result
o_zero  out  1  result == 0
o_carry  out  1  ADD carry-out / SUB borrow
o_overflow  out  1  signed overflow (ADD/SUB only)
o_err  out  1  last executed opcode invalid
o_valid  out  1  one-cycle pulse when a new result is registered
o_busy  out  1  high while FSM is in EXEC

Behaviour:
Reset:
- All outputs are 0.
- All synchroniser and edge flops are 0.
- FSM is in IDLE.
- Reset dominates every other input.

Input path:
- Each button passes through NB_SYNC flops, then one delay flop.
- edge = sync_out & ~delayed.
- A button held high produces exactly one edge.
- i_switch is sampled unsynchronised at the action edge; the user holds the switches steady.

Latency:
- Button first sampled high at clock edge k gives the action at edge k+NB_SYNC.
- With defaults, o_a is updated at edge k+2.

Priority:
- If several edges coincide: a > b > op > exec.
- Lower-priority coincident edges are discarded, not queued.

FSM, IDLE:
- edge_a: o_a <= i_switch.
- edge_b: o_b <= i_switch.
- edge_op: o_opcode <= i_switch[NB_OPCODE-1:0].
- edge_exec: snapshot a/b/opcode, go to EXEC, o_busy=1.

FSM, EXEC (exactly 1 cycle):
- Register o_result and all flags from the snapshot.
- o_valid=1 during the following cycle.
- o_busy=0 and return to IDLE.
- All button edges arriving during EXEC are dropped.

Opcodes (6-bit values; zero-extended/truncated for other NB_OPCODE):
- 100000 ADD
- 100010 SUB
- 100100 AND
- 100101 OR
- 100110 XOR
- 100111 NOR
- 000011 SRA
- 000010 SRL

Arithmetic and flags:
- All results are truncated to NB_DATA.
- ADD: carry = bit NB_DATA of a+b (unsigned). Overflow = sign(a)==sign(b) and sign(result)!=sign(a).
- SUB: a-b; carry = borrow = (a<b unsigned). Overflow = sign(a)!=sign(b) and sign(result)!=sign(a).
- Logic ops: carry=0, overflow=0.
- SRL/SRA: shift a by b treated unsigned; carry=0, overflow=0.
  - If b >= NB_DATA: SRL gives 0; SRA gives all bits equal to a's MSB.
- Invalid opcode: o_result=0, o_err=1, carry=0, overflow=0, o_zero=1.
- Any valid opcode: o_err=0.
- o_zero is computed from the new result.
- Flags and result hold until the next EXEC or reset.

Mid-operation:
- Reset during EXEC: no o_valid pulse; all outputs return to 0 at that edge.
- Changing switches or operands after the exec edge does not affect the in-flight result.

Test Plan:
1. Reset, then load A=0x05, B=0x03, op=100000, exec -> o_result=0x08, zero=0, carry=0, overflow=0, o_valid exactly 1 cycle, o_a updated 2 cycles after first sampled button edge.
2. A=0x7F, B=0x01, ADD -> result=0x80, overflow=1, carry=0. Then A=0xFF, B=0x01, ADD -> result=0x00, carry=1, zero=1, overflow=0.
3. A=0x03, B=0x05, SUB -> result=0xFE, carry(borrow)=1. A=0x80, B=0x01, SUB -> result=0x7F, overflow=1.
4. A=0x90, B=0x02, SRA -> 0xE4; SRL -> 0x24. B=0x09: SRA -> 0xFF, SRL -> 0x00.
5. op=111111, exec -> result=0x00, o_err=1, o_zero=1. Then op=100100 with A=0xF0, B=0x3C -> result=0x30, o_err=0.
6. Edge cases:
   - btn_a and btn_b rise the same cycle -> only A loads.
   - btn_a held 50 cycles -> single load.
   - btn_b edge during EXEC -> B unchanged.
   - Reset asserted during EXEC -> no o_valid, all outputs 0.
